// File: rtl/serial_pkg.sv
// Shared definitions for the RS-232 transmit and receive blocks.
package serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int FRAME_BITS = 10;

  function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/serial_baud_timer.sv
// Bit-period counter: counts 0..DIVISOR-1 while enabled, pulses bit_tick_o on the last count.
module serial_baud_timer #(
  parameter int DIVISOR = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_tick_o
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("serial_baud_timer: DIVISOR must be at least 2");
  end

  localparam int CW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bit_tick_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/serial_tx_sink.sv
// Stb/ack word sink that sends bits 7:0 of each accepted word as one 8N1 frame on tx.
module serial_tx_sink
  import serial_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_in,
  input  logic        input_in_stb,
  output logic        input_in_ack,
  output logic        tx
);

  localparam int DIVISOR = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);

  state_e     state_q;
  logic       ack_q;
  logic       tx_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic       bit_tick;
  logic       xfer;

  logic unused_hi;
  assign unused_hi = ^input_in[31:8];

  assign xfer = (state_q == IDLE) && input_in_stb && ack_q;

  serial_baud_timer #(.DIVISOR(DIVISOR)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (xfer),
    .enable_i  (state_q != IDLE),
    .bit_tick_o(bit_tick)
  );

  // tx is registered from the next-state decision so the line changes on the same edge as state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (xfer) begin
            shift_q <= input_in[7:0];
            ack_q   <= 1'b0;
            tx_q    <= 1'b0;
            state_q <= START;
          end else begin
            // A dropped stb withdraws the offer without taking a word.
            ack_q <= input_in_stb;
          end
        end
        START: if (bit_tick) begin
          bit_idx_q <= '0;
          tx_q      <= shift_q[0];
          state_q   <= DATA;
        end
        DATA: if (bit_tick) begin
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tx_q <= shift_q[1];
          end
        end
        STOP: if (bit_tick) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign input_in_ack = ack_q;
  assign tx           = tx_q;

endmodule

// File: tb/tb_serial_tx_sink.sv
// Directed bench for serial_tx_sink at 16 clocks per bit.
module tb_serial_tx_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_in = '0;
  logic        input_in_stb = 1'b0;
  logic        input_in_ack;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;

  serial_tx_sink #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .input_in    (input_in),
    .input_in_stb(input_in_stb),
    .input_in_ack(input_in_ack),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records one frame starting at the start-bit cycle; leaves the bench 160 cycles later.
  task automatic capture_frame(output logic [9:0] bits, output int bad_hold, output int ack_hi);
    bits = '0; bad_hold = 0; ack_hi = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) begin
        if (c == 0) bits[b] = tx;
        else if (tx !== bits[b]) bad_hold++;
        if (input_in_ack !== 1'b0) ack_hi++;
        tick();
      end
    end
  endtask

  // Offers a word from IDLE, checks the one-cycle ack and the start-bit fall, then drops stb.
  task automatic send_word(input logic [31:0] w, input string name);
    input_in = w; input_in_stb = 1'b1;
    tick();
    n_tests++;
    if (input_in_ack !== 1'b1) begin n_fail++; $display("FAIL %s ack_cycle1: got %b want 1", name, input_in_ack); end
    tick();
    n_tests++;
    if (input_in_ack !== 1'b0 || tx !== 1'b0) begin
      n_fail++; $display("FAIL %s cycle2: ack=%b tx=%b want ack=0 tx=0", name, input_in_ack, tx);
    end
    input_in_stb = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b0; input_in_stb = 1'b1; input_in = 32'h0000_0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx !== 1'b1 || input_in_ack !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_hold: %0d bad cycles want 0", bad); end
    rst = 1'b1;
    tick();
    n_tests++;
    if (input_in_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack_rise: got %b want 1", input_in_ack); end
    // Withdraw the offer while ack is high: no word may be taken.
    input_in_stb = 1'b0;
    tick();
    n_tests++;
    if (input_in_ack !== 1'b0) begin n_fail++; $display("FAIL stb_drop_ack: got %b want 0", input_in_ack); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stb_drop_no_frame: %0d low cycles want 0", bad); end
  endtask

  task automatic test_frame(input logic [31:0] w, input logic [9:0] exp, input string name);
    logic [9:0] bits; int bad_hold, ack_hi;
    send_word(w, name);
    capture_frame(bits, bad_hold, ack_hi);
    n_tests++;
    if (bits !== exp) begin n_fail++; $display("FAIL %s bits: got %b want %b", name, bits, exp); end
    n_tests++;
    if (bad_hold != 0 || ack_hi != 0) begin
      n_fail++; $display("FAIL %s timing: hold_err=%0d ack_hi=%0d want 0/0", name, bad_hold, ack_hi);
    end
    n_tests++;
    if (tx !== 1'b1 || input_in_ack !== 1'b0) begin
      n_fail++; $display("FAIL %s after_frame: tx=%b ack=%b want 1/0", name, tx, input_in_ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits; int bad_hold, ack_hi, n, acks;
    input_in = 32'h41; input_in_stb = 1'b1;
    tick(); tick();
    input_in = 32'h42;
    capture_frame(bits, bad_hold, ack_hi);
    n_tests++;
    if (bits !== 10'h282 || bad_hold != 0 || ack_hi != 0) begin
      n_fail++; $display("FAIL b2b_first: bits=%b hold=%0d ack=%0d want %b/0/0", bits, bad_hold, ack_hi, 10'h282);
    end
    n = 160; acks = 0;
    while (tx !== 1'b0 && n < 200) begin
      if (input_in_ack === 1'b1) acks++;
      tick(); n++;
    end
    n_tests++;
    if (n != 162 || acks != 1) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles %0d acks want 162 cycles 1 ack", n, acks);
    end
    input_in_stb = 1'b0;
    capture_frame(bits, bad_hold, ack_hi);
    n_tests++;
    if (bits !== 10'h284 || bad_hold != 0 || ack_hi != 0) begin
      n_fail++; $display("FAIL b2b_second: bits=%b hold=%0d ack=%0d want %b/0/0", bits, bad_hold, ack_hi, 10'h284);
    end
  endtask

  task automatic test_data_change();
    logic [9:0] bits; int bad_hold, ack_hi;
    input_in = 32'h3C; input_in_stb = 1'b1;
    tick(); tick();
    input_in = 32'h00; input_in_stb = 1'b0;
    capture_frame(bits, bad_hold, ack_hi);
    n_tests++;
    if (bits !== 10'h278 || bad_hold != 0) begin
      n_fail++; $display("FAIL data_change: bits=%b hold=%0d want %b/0", bits, bad_hold, 10'h278);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send_word(32'h96, "mid");
    for (int i = 0; i < 70; i++) tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (tx !== 1'b1 || input_in_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: tx=%b ack=%b want 1/0", tx, input_in_ack);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_mid_idle: %0d low cycles want 0", bad); end
    test_frame(32'h55, 10'h2AA, "after_reset");
  endtask

  initial begin
    test_reset();
    test_frame(32'h0000_00A5, 10'h34A, "single_a5");
    test_frame(32'hFFFF_FF00, 10'h200, "upper_ignored");
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
